classifier_feat_sequencer: RTL and testbench
============================================

# classifier_feat_sequencer

Control stage directly upstream of the final-layer MAC/ArgMax unit. It holds one frame of int4 feature activations and walks every class × feature pair. For each pair it fetches the int8 weight from an external synchronous weight ROM and presents it together with the feature to the MAC. It emits exactly the `new_feat` / `new_class` / `class_id` event stream that unit consumes, one class at a time, and reports `busy` / `done` to the layer controller.

## Interface
- `N_FEAT`, 16: features per class (≥2).
- `N_CLASS`, 8: number of classes (≥2, ≤ 2^`CLASS_BITS`).
- `CLASS_BITS`, 3: class index width; must match the MAC unit.
- `FEAT_BITS`, `$clog2(N_FEAT)`: feature index width.
- `ADDR_BITS`, `$clog2(N_FEAT*N_CLASS)`: weight ROM address width.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `feat_we`  in  1  feature buffer write strobe.
- `feat_waddr`  in  `FEAT_BITS`  feature buffer write index.
- `feat_wdata`  in  4  signed int4 feature.
- `start`  in  1  1-cycle pulse; begins one frame pass.
- `abort`  in  1  synchronous cancel of the current pass.
- `w_addr`  out  `ADDR_BITS`  weight ROM address.
- `w_rdata`  in  8  signed int8 weight; valid 1 cycle after `w_addr`.
- `x_int4`  out  4  feature to MAC.
- `w_int8`  out  8  weight to MAC; combinational from `w_rdata`.
- `new_feat`  out  1  (`x_int4`, `w_int8`) valid this cycle.
- `new_class`  out  1  current class score complete.
- `class_id`  out  `CLASS_BITS`  class being closed; valid when `new_class`=1.
- `busy`  out  1  pass in progress.
- `done`  out  1  1-cycle pulse; pass complete.

## Operation
- Feature buffer: `N_FEAT`×4-bit register file.
  - Written when `feat_we` && !`busy`; writes while `busy` are dropped.
  - Contents are not cleared by `start`; they are cleared to 0 by reset.
- Weight address = `c*N_FEAT + f`, where c = class counter and f = feature counter.
- FSM states:
  - **IDLE**: `start` → RUN, with c=0, f=0.
  - **RUN**: drive `w_addr`(c,f) and register buf[f] into `x_int4`. f increments each cycle. When f=`N_FEAT`-1 is issued, go to WAIT.
  - **WAIT**: one cycle; the last product of the class appears on `new_feat`. Go to CLOSE.
  - **CLOSE**: assert `new_class`=1 with `class_id`=c and `new_feat`=0. If c=`N_CLASS`-1, go to DONE; else c++, f=0, go to RUN.
  - **DONE**: assert `done`=1 for one cycle, then go to IDLE.
- Pipeline: `new_feat` is the RUN-issue flag delayed by one register, aligned with `w_rdata`.
- `new_feat` and `new_class` are never high in the same cycle. Keeping them apart is required because the MAC's clear has priority over accumulate.
- `start` while `busy` is ignored.
- `abort` (any state ≠ IDLE):
  - Next state is IDLE; c and f are cleared.
  - `new_feat`, `new_class` and `done` are forced to 0 from the next cycle.
  - A class is never partially closed.
  - `abort` wins over a simultaneous `start`.
- Counters wrap only by explicit reload; f never exceeds `N_FEAT`-1 and c never exceeds `N_CLASS`-1.

## Timing
- Reset values:
  - State IDLE; c=0, f=0; buffer all 0.
  - `w_addr`=0, `x_int4`=0, `new_feat`=0, `new_class`=0, `class_id`=0, `busy`=0, `done`=0.
- `busy`=1 from the cycle after `start` through the DONE cycle inclusive.
- `start` at cycle 0:
  - First `w_addr` at cycle 1; first `new_feat` at cycle 2.
  - Per class: `N_FEAT` `new_feat` pulses, followed by one `new_class` cycle.
  - Class k closes at cycle (k+1)(`N_FEAT`+2).
  - `done` at cycle `N_CLASS`(`N_FEAT`+2)+1. Defaults: 145.
- Reset asserted mid-pass: all outputs return to reset values asynchronously. No `done` is emitted.

## Structure
- Shared package `classifier_pkg`:
  - `N_FEAT` / `N_CLASS` / `CLASS_BITS` defaults.
  - int4 / int8 / score typedefs.
  - Sequencer state enum (IDLE, RUN, WAIT, CLOSE, DONE).
- Sub-module `classifier_feat_buf`: register file with 1 write port and 1 registered read port.
- FSM and counters stay in the top module.

## Test plan
- **Full pass**: load features f=1 for all indices; ROM weight = class index + 1; `start`.
  - Expect 8×16 `new_feat` pulses, `new_class` at cycles 18, 36 … 144 with `class_id` 0..7, `done` at 145.
  - With the MAC attached: `max_class`=7, `max_score`=128.
- **Address and order check**: `N_FEAT`=4, `N_CLASS`=3. `w_addr` sequence is exactly 0..11, with a 2-cycle gap after each 4 addresses.
- **Signed data**: feature=-8, weight=-128. Expect `x_int4`=4'h8, `w_int8`=8'h80 on `new_feat`; MAC class score = 16384.
- **`start` during `busy`**: pulse `start` at cycle 50. Expect no restart; `done` still at 145. Writes with `feat_we` at cycle 60 leave the buffer unchanged.
- **`abort` in CLOSE of class 2**: `new_class` still pulses that cycle. Next cycle: IDLE, `busy`=0, no further pulses, no `done`. A new `start` then produces a full 145-cycle pass.
- **Async reset at cycle 70**: all outputs return to 0 immediately; the feature buffer is cleared.

Source files
------------

// File: rtl/classifier_feat_sequencer_pkg.sv
// Shared types and defaults for the final-layer classifier datapath.
package classifier_pkg;

  localparam int N_FEAT_DEF     = 16;
  localparam int N_CLASS_DEF    = 8;
  localparam int CLASS_BITS_DEF = 3;

  typedef logic signed [3:0]  int4_t;
  typedef logic signed [7:0]  int8_t;
  typedef logic signed [23:0] score_t;

  typedef enum logic [2:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_RUN   = 3'd1,
    SEQ_WAIT  = 3'd2,
    SEQ_CLOSE = 3'd3,
    SEQ_DONE  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/classifier_feat_sequencer_if.sv
// Weight ROM and MAC-facing bus of the feature sequencer.
interface classifier_feat_sequencer_if
  import classifier_pkg::*;
#(
  parameter int ADDR_BITS  = 7,
  parameter int CLASS_BITS = 3
);

  logic [ADDR_BITS-1:0]  w_addr;
  int8_t                 w_rdata;
  int4_t                 x_int4;
  int8_t                 w_int8;
  logic                  new_feat;
  logic                  new_class;
  logic [CLASS_BITS-1:0] class_id;

  modport master (
    output w_addr, x_int4, w_int8, new_feat, new_class, class_id,
    input  w_rdata
  );

  modport slave (
    input  w_addr, x_int4, w_int8, new_feat, new_class, class_id,
    output w_rdata
  );

endinterface

// File: rtl/classifier_feat_sequencer_feat_buf.sv
// Feature activation register file: one write port, one registered read port.
module classifier_feat_buf
  import classifier_pkg::*;
#(
  parameter int N  = 16,
  parameter int AW = 4
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  int4_t         wr_data,
  input  logic [AW-1:0] rd_addr,
  output int4_t         rd_data
);

  int4_t mem_r [N];
  int4_t rd_data_r;

  // Storage write and registered read; reset clears every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        mem_r[i] <= 4'sd0;
      end
      rd_data_r <= 4'sd0;
    end else begin
      if (wr_en && (int'(wr_addr) < N)) begin
        mem_r[wr_addr] <= wr_data;
      end
      rd_data_r <= mem_r[rd_addr];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/classifier_feat_sequencer.sv
// Walks every class x feature pair, fetching weights and feeding the MAC/ArgMax unit.
module classifier_feat_sequencer
  import classifier_pkg::*;
#(
  parameter int N_FEAT     = N_FEAT_DEF,
  parameter int N_CLASS    = N_CLASS_DEF,
  parameter int CLASS_BITS = CLASS_BITS_DEF,
  parameter int FEAT_BITS  = $clog2(N_FEAT),
  parameter int ADDR_BITS  = $clog2(N_FEAT * N_CLASS)
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  feat_we,
  input  logic [FEAT_BITS-1:0]  feat_waddr,
  input  int4_t                 feat_wdata,
  input  logic                  start,
  input  logic                  abort,
  classifier_feat_sequencer_if.master mac_bus,
  output logic                  busy,
  output logic                  done
);

  localparam logic [2:0] ST_IDLE  = SEQ_IDLE;
  localparam logic [2:0] ST_RUN   = SEQ_RUN;
  localparam logic [2:0] ST_WAIT  = SEQ_WAIT;
  localparam logic [2:0] ST_CLOSE = SEQ_CLOSE;
  localparam logic [2:0] ST_DONE  = SEQ_DONE;

  localparam logic [FEAT_BITS-1:0]  F_LAST = FEAT_BITS'(N_FEAT - 1);
  localparam logic [CLASS_BITS-1:0] C_LAST = CLASS_BITS'(N_CLASS - 1);

  logic [2:0]            state_r, state_s;
  logic [CLASS_BITS-1:0] c_r, c_s;
  logic [FEAT_BITS-1:0]  f_r, f_s;
  logic                  issue_r;
  logic                  buf_we_s;
  int4_t                 feat_rd_s;

  // Flat weight ROM address: class-major, feature-minor.
  function automatic logic [ADDR_BITS-1:0] weight_addr(
    input logic [CLASS_BITS-1:0] c,
    input logic [FEAT_BITS-1:0]  f
  );
    return (ADDR_BITS'(c) * ADDR_BITS'(N_FEAT)) + ADDR_BITS'(f);
  endfunction

  // Writes are only accepted between passes so a frame stays stable while walked.
  assign buf_we_s = feat_we && !busy;

  classifier_feat_buf #(
    .N  (N_FEAT),
    .AW (FEAT_BITS)
  ) u_feat_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (buf_we_s),
    .wr_addr (feat_waddr),
    .wr_data (feat_wdata),
    .rd_addr (f_r),
    .rd_data (feat_rd_s)
  );

  // Next state and counter reloads; abort overrides everything, including start.
  always_comb begin
    state_s = state_r;
    c_s     = c_r;
    f_s     = f_r;
    if (abort) begin
      state_s = ST_IDLE;
      c_s     = {CLASS_BITS{1'b0}};
      f_s     = {FEAT_BITS{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_s = ST_RUN;
            c_s     = {CLASS_BITS{1'b0}};
            f_s     = {FEAT_BITS{1'b0}};
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (f_r == F_LAST) begin
            state_s = ST_WAIT;
          end else begin
            f_s = f_r + 1'b1;
          end
        end
        ST_WAIT: begin
          state_s = ST_CLOSE;
        end
        ST_CLOSE: begin
          if (c_r == C_LAST) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_RUN;
            c_s     = c_r + 1'b1;
            f_s     = {FEAT_BITS{1'b0}};
          end
        end
        ST_DONE: begin
          state_s = ST_IDLE;
          c_s     = {CLASS_BITS{1'b0}};
          f_s     = {FEAT_BITS{1'b0}};
        end
        default: begin
          state_s = ST_IDLE;
          c_s     = {CLASS_BITS{1'b0}};
          f_s     = {FEAT_BITS{1'b0}};
        end
      endcase
    end
  end

  // State, counters and the issue flag that becomes new_feat one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      c_r     <= {CLASS_BITS{1'b0}};
      f_r     <= {FEAT_BITS{1'b0}};
      issue_r <= 1'b0;
    end else begin
      state_r <= state_s;
      c_r     <= c_s;
      f_r     <= f_s;
      issue_r <= (state_r == ST_RUN) && !abort;
    end
  end

  // new_feat only exists in RUN+1/WAIT and new_class only in CLOSE, so they never overlap.
  assign mac_bus.w_addr    = weight_addr(c_r, f_r);
  assign mac_bus.x_int4    = feat_rd_s;
  assign mac_bus.w_int8    = mac_bus.w_rdata;
  assign mac_bus.new_feat  = issue_r;
  assign mac_bus.new_class = (state_r == ST_CLOSE);
  assign mac_bus.class_id  = c_r;
  assign busy              = (state_r != ST_IDLE);
  assign done              = (state_r == ST_DONE);

endmodule

// File: tb/tb_classifier_feat_sequencer.sv
// Self-checking bench: cycle-indexed reference of the class/feature event stream.
module tb_classifier_feat_sequencer;
  import classifier_pkg::*;

  localparam int NF     = 16;
  localparam int NC     = 8;
  localparam int P      = NF + 2;
  localparam int DONE_T = NC * P + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       feat_we = 1'b0;
  logic [3:0] feat_waddr = 4'd0;
  int4_t      feat_wdata = 4'sd0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       busy;
  logic       done;

  classifier_feat_sequencer_if #(.ADDR_BITS(7), .CLASS_BITS(3)) bus ();

  classifier_feat_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .feat_we    (feat_we),
    .feat_waddr (feat_waddr),
    .feat_wdata (feat_wdata),
    .start      (start),
    .abort      (abort),
    .mac_bus    (bus),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int4_t feat_m [NF];
  int8_t rom [NF*NC];
  int    checks = 0;
  int    errors = 0;
  int    acc;

  // Synchronous weight ROM: data one cycle after the address.
  always @(posedge clk) bus.w_rdata <= rom[bus.w_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_score(input int k);
    int s;
    s = 0;
    for (int j = 0; j < NF; j++) s += int'(feat_m[j]) * int'(rom[k*NF + j]);
    return s;
  endfunction

  task automatic load_feats(input int mode);
    int4_t v;
    for (int i = 0; i < NF; i++) begin
      if (mode == 0) v = 4'sd1;
      else if (mode == 1) v = -4'sd8;
      else v = int4_t'($urandom_range(0, 15));
      feat_we = 1'b1; feat_waddr = 4'(i); feat_wdata = v; feat_m[i] = v;
      @(posedge clk); #1;
    end
    feat_we = 1'b0;
  endtask

  task automatic set_rom(input int mode);
    for (int a = 0; a < NF*NC; a++) begin
      if (mode == 0) rom[a] = int8_t'(a / NF + 1);
      else if (mode == 1) rom[a] = -8'sd128;
      else rom[a] = int8_t'($urandom_range(0, 255));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_new_feat"}, 32'(bus.new_feat), 32'd0);
    chk({tag, "_new_class"}, 32'(bus.new_class), 32'd0);
    chk({tag, "_class_id"}, 32'(bus.class_id), 32'd0);
    chk({tag, "_w_addr"}, 32'(bus.w_addr), 32'd0);
    chk({tag, "_x_int4"}, 32'(bus.x_int4), 32'd0);
  endtask

  // Expected outputs t cycles after start; nothing is live past cycle 'last'.
  task automatic check_cycle(input int t, input int last);
    bit live, busy_e, done_e, nc_e, nf_e, run_e;
    int kf, jf, kr, jr;
    live   = (t <= last);
    busy_e = live && t >= 1 && t <= DONE_T;
    done_e = live && t == DONE_T;
    nc_e   = live && t >= P && t <= NC*P && (t % P) == 0;
    kf = (t - 2) / P; jf = (t - 2) % P;
    kr = (t - 1) / P; jr = (t - 1) % P;
    nf_e   = live && t >= 2 && kf < NC && jf < NF;
    run_e  = live && t >= 1 && kr < NC && jr < NF;
    chk("busy", 32'(busy), 32'(busy_e));
    chk("done", 32'(done), 32'(done_e));
    chk("new_class", 32'(bus.new_class), 32'(nc_e));
    chk("new_feat", 32'(bus.new_feat), 32'(nf_e));
    if (nc_e) chk("class_id", 32'(bus.class_id), 32'(t / P - 1));
    if (nf_e) begin
      chk("x_int4", 32'(bus.x_int4), 32'(feat_m[jf]));
      chk("w_int8", 32'(bus.w_int8), 32'(rom[kf*NF + jf]));
    end
    if (run_e) chk("w_addr", 32'(bus.w_addr), 32'(kr*NF + jr));
  endtask

  task automatic run_pass(input int abort_t, input int reset_t, input bit poke);
    int last;
    int a;
    last = (abort_t > 0) ? abort_t : DONE_T;
    acc = 0;
    @(posedge clk); #1;
    check_cycle(0, -1);
    start = 1'b1;
    for (int t = 1; t <= DONE_T + 2; t++) begin
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0; feat_we = 1'b0;
      check_cycle(t, last);
      if (bus.new_feat === 1'b1) acc += int'(bus.x_int4) * int'(bus.w_int8);
      if (bus.new_class === 1'b1 && t >= P && (t / P - 1) < NC) begin
        chk("class_score", 32'(acc), 32'(exp_score(t / P - 1)));
        acc = 0;
      end
      if (t == abort_t) abort = 1'b1;
      if (poke && t == 50) start = 1'b1;
      if (poke && t == 60) begin
        a = $urandom_range(0, NF - 1);
        feat_we = 1'b1; feat_waddr = 4'(a); feat_wdata = int4_t'(~feat_m[a]);
      end
      if (t == reset_t) begin
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < NF; i++) feat_m[i] = 4'sd0;
        return;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NF; i++) feat_m[i] = 4'sd0;
    set_rom(0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("post_reset");

    load_feats(0); set_rom(0); run_pass(0, 0, 1'b0);
    load_feats(1); set_rom(1); run_pass(0, 0, 1'b0);
    load_feats(2); set_rom(2); run_pass(0, 0, 1'b1);
    run_pass(3*P, 0, 1'b0);
    run_pass(0, 0, 1'b0);
    run_pass(0, 70, 1'b0);
    set_rom(2); run_pass(0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
